// File: rtl/mux_gate_sequencer.sv
// mux_gate_sequencer: bit-serial word logic unit.
// One shared 2:1 mux cell evaluates NOT/AND/OR/NAND/NOR/XOR/XNOR, one bit per
// clock and LSB first. The operand bit a[i] drives the mux select, and the
// opcode decides which values are presented on the two data legs.
module mux_gate_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] y
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [2:0]         op_q,    op_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic [WIDTH-1:0]   sh_q,    sh_d;
    logic [WIDTH-1:0]   y_q,     y_d;
    logic               err_q,   err_d;
    logic               bit_s;

    // Shared mux cell: select = a bit, data legs chosen by the opcode.
    function automatic logic mux_gate(input logic [2:0] opc,
                                      input logic       sel,
                                      input logic       bi);
        logic in0;
        logic in1;
        case (opc)
            3'd0:    begin in0 = 1'b1; in1 = 1'b0; end
            3'd1:    begin in0 = 1'b0; in1 = bi;   end
            3'd2:    begin in0 = bi;   in1 = 1'b1; end
            3'd3:    begin in0 = 1'b1; in1 = ~bi;  end
            3'd4:    begin in0 = ~bi;  in1 = 1'b0; end
            3'd5:    begin in0 = bi;   in1 = ~bi;  end
            3'd6:    begin in0 = ~bi;  in1 = bi;   end
            default: begin in0 = 1'b0; in1 = 1'b0; end
        endcase
        return sel ? in1 : in0;
    endfunction

    // Next-state, capture, and shift logic for the three-state sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        y_d     = y_q;
        err_d   = err_q;
        bit_s   = mux_gate(op_q, a_q[cnt_q], b_q[cnt_q]);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op != 3'd7) begin
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        cnt_d   = {CNT_W{1'b0}};
                        sh_d    = {WIDTH{1'b0}};
                        err_d   = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        // Illegal opcode: report immediately, keep y untouched.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // New bits enter at the MSB so bit 0 ends at the LSB after WIDTH shifts.
                sh_d = {bit_s, sh_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    y_d     = sh_d;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 3'd0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sh_q    <= {WIDTH{1'b0}};
            y_q     <= {WIDTH{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign err  = err_q;
    assign y    = y_q;

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// Directed self-checking bench for mux_gate_sequencer (WIDTH=8).
module tb_mux_gate_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] y;

    int checks   = 0;
    int failures = 0;
    int bcnt;
    int dcnt;

    mux_gate_sequencer #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns with the bench sitting in the cycle after RUN ends.
    // mode 1 scrambles inputs each RUN cycle, mode 2 pulses a NAND start mid-run.
    task automatic do_op(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input int mode, output int busy_cycles);
        start = 1'b1; op = o; a = av; b = bv;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            if (done !== 1'b0) chk("done_during_busy", 32'(done), 32'd0);
            if (mode == 1) begin
                op = 3'($urandom_range(0, 7));
                a  = 8'($urandom);
                b  = 8'($urandom);
            end else if (mode == 2) begin
                start = (busy_cycles == 3);
                op    = 3'd3;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err",  32'(err),  32'd0);
        chk("reset_y",    32'(y),    32'h00);
        rst = 1'b0;
        tick();

        // AND F0 & CC = C0, 8 busy cycles then done
        do_op(3'd1, 8'hF0, 8'hCC, 0, bcnt);
        chk("and_busy_cycles", 32'(bcnt), 32'd8);
        chk("and_done", 32'(done), 32'd1);
        chk("and_y",    32'(y),    32'hC0);
        chk("and_err",  32'(err),  32'd0);
        tick();
        chk("and_done_one_cycle", 32'(done), 32'd0);

        // XOR then XNOR back to back, second start on first IDLE cycle
        do_op(3'd5, 8'hA5, 8'h3C, 0, bcnt);
        chk("xor_busy_cycles", 32'(bcnt), 32'd8);
        chk("xor_done", 32'(done), 32'd1);
        chk("xor_y",    32'(y),    32'h99);
        tick();
        do_op(3'd6, 8'hA5, 8'h3C, 0, bcnt);
        chk("xnor_busy_cycles", 32'(bcnt), 32'd8);
        chk("xnor_done", 32'(done), 32'd1);
        chk("xnor_y",    32'(y),    32'h66);
        tick();

        // NOT with inputs scrambled during RUN
        do_op(3'd0, 8'h0F, 8'hFF, 1, bcnt);
        chk("not_busy_cycles", 32'(bcnt), 32'd8);
        chk("not_done", 32'(done), 32'd1);
        chk("not_y",    32'(y),    32'hF0);
        tick();

        // restore y=0x66 via XNOR, then illegal op
        do_op(3'd6, 8'hA5, 8'h3C, 0, bcnt);
        tick();
        do_op(3'd7, 8'h12, 8'h34, 0, bcnt);
        chk("ill_busy_cycles", 32'(bcnt), 32'd0);
        chk("ill_done", 32'(done), 32'd1);
        chk("ill_err",  32'(err),  32'd1);
        chk("ill_y",    32'(y),    32'h66);
        tick();
        chk("ill_done_drop", 32'(done), 32'd0);
        chk("ill_err_hold",  32'(err),  32'd1);
        chk("ill_busy_idle", 32'(busy), 32'd0);

        // OR after illegal clears err
        do_op(3'd2, 8'h12, 8'h34, 0, bcnt);
        chk("or_busy_cycles", 32'(bcnt), 32'd8);
        chk("or_done", 32'(done), 32'd1);
        chk("or_err",  32'(err),  32'd0);
        chk("or_y",    32'(y),    32'h36);
        tick();

        // NOR with an ignored NAND start mid-run: exactly one done
        do_op(3'd4, 8'h81, 8'h18, 2, bcnt);
        chk("nor_busy_cycles", 32'(bcnt), 32'd8);
        chk("nor_done", 32'(done), 32'd1);
        chk("nor_y",    32'(y),    32'h66);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        chk("nor_single_done", 32'(dcnt), 32'd0);

        // Reset in the middle of an AND run
        start = 1'b1; op = 3'd1; a = 8'hFF; b = 8'hFF;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_done", 32'(done), 32'd0);
        chk("rst_async_err",  32'(err),  32'd0);
        chk("rst_async_y",    32'(y),    32'h00);
        tick();
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        chk("rst_no_done", 32'(dcnt), 32'd0);
        chk("rst_y_hold",  32'(y),    32'h00);

        do_op(3'd2, 8'h00, 8'h00, 0, bcnt);
        chk("or0_busy_cycles", 32'(bcnt), 32'd8);
        chk("or0_done", 32'(done), 32'd1);
        chk("or0_y",    32'(y),    32'h00);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
